// File: rtl/fifo_burst_writer.sv
// FIFO write-port traffic source: emits tagged, sequenced bursts
// under a valid/ready handshake for FIFO bring-up and stress runs.
module fifo_burst_writer #(
    parameter int FIFO_WIDTH  = 8,
    parameter int TAG_WIDTH   = 3,
    parameter int LEN_WIDTH   = 8,
    parameter int GAP_WIDTH   = 4,
    parameter int STALL_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [LEN_WIDTH-1:0]            burstLen,
    input  logic [GAP_WIDTH-1:0]            gapCycles,
    input  logic                            mode,
    input  logic [FIFO_WIDTH-TAG_WIDTH-1:0] seed,
    input  logic                            writeReady,
    output logic                            writeValid,
    output logic [FIFO_WIDTH-1:0]           writeData,
    output logic                            busy,
    output logic                            done,
    output logic [LEN_WIDTH-1:0]            wordsSent,
    output logic [STALL_WIDTH-1:0]          stallCycles
);

    localparam int PW = FIFO_WIDTH - TAG_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } stateT;

    stateT                state;
    logic [LEN_WIDTH-1:0] lenR;
    logic [GAP_WIDTH-1:0] gapR;
    logic                 modeR;
    logic [PW-1:0]        seedR;
    logic [GAP_WIDTH-1:0] gapCnt;
    logic [TAG_WIDTH-1:0] tag;

    logic [LEN_WIDTH-1:0] nextCnt;
    logic [TAG_WIDTH-1:0] tagNext;
    logic                 lastWord;

    function automatic logic [PW-1:0] payload(
        input logic                 m,
        input logic [PW-1:0]        s,
        input logic [LEN_WIDTH-1:0] k
    );
        logic [PW-1:0] kp;
        kp = PW'(k);
        return m ? (s ^ kp) : (s + kp);
    endfunction

    assign nextCnt  = wordsSent + 1'b1;
    assign tagNext  = tag + 1'b1;
    assign lastWord = (nextCnt == lenR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lenR        <= '0;
            gapR        <= '0;
            modeR       <= 1'b0;
            seedR       <= '0;
            gapCnt      <= '0;
            tag         <= '0;
            writeValid  <= 1'b0;
            writeData   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wordsSent   <= '0;
            stallCycles <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lenR      <= burstLen;
                        gapR      <= gapCycles;
                        modeR     <= mode;
                        seedR     <= seed;
                        wordsSent <= '0;
                        busy      <= 1'b1;
                        if (burstLen != '0) begin
                            writeValid <= 1'b1;
                            writeData  <= {tag, seed};
                            state      <= SEND;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SEND: begin
                    if (writeReady) begin
                        wordsSent <= nextCnt;
                        tag       <= tagNext;
                        if (lastWord) begin
                            writeValid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else if (gapR == '0) begin
                            writeData <= {tagNext, payload(modeR, seedR, nextCnt)};
                        end else begin
                            writeValid <= 1'b0;
                            gapCnt     <= gapR;
                            state      <= GAP;
                        end
                    end else if (stallCycles != '1) begin
                        stallCycles <= stallCycles + 1'b1;
                    end
                end
                GAP: begin
                    if (gapCnt == GAP_WIDTH'(1)) begin
                        writeValid <= 1'b1;
                        writeData  <= {tag, payload(modeR, seedR, wordsSent)};
                        state      <= SEND;
                    end else begin
                        gapCnt <= gapCnt - 1'b1;
                    end
                end
                DONE: begin
                    // Zero-length bursts arrive here with done low and
                    // spend one extra cycle so the pulse lands a cycle later.
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
